// File: rtl/serial_mag_comparator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmp_pkg
// Purpose  : Shared types for the serial magnitude comparator. Holds the
//            controller state encoding, the 2-bit slice result encoding and
//            a helper for the width of the pair index.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cmp_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Result of one 2-bit slice compare
  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_GT = 2'b01,
    CMP_LT = 2'b10
  } cmp_res_t;

  // Width of an index that counts n pairs. A single pair still needs a
  // one-bit register so the index never collapses to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_mag_comparator_cmp2_slice.sv
`default_nettype none
// ============================================================================
// Module   : cmp2_slice
// Purpose  : Purely combinational unsigned compare of two 2-bit values,
//            returning the cmp_pkg slice encoding.
// Ports    : i_a   [1:0]  operand A pair
//            i_b   [1:0]  operand B pair
//            o_res [1:0]  CMP_EQ / CMP_GT / CMP_LT
// Revision : 1.0 - initial release
// ============================================================================
module cmp2_slice
  import cmp_pkg::*;
(
  input  logic     [1:0] i_a,
  input  logic     [1:0] i_b,
  output cmp_res_t       o_res
);

  always_comb begin
    o_res = CMP_EQ;
    if (i_a > i_b) begin
      o_res = CMP_GT;
    end else if (i_a < i_b) begin
      o_res = CMP_LT;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_mag_comparator.sv
`default_nettype none
// ============================================================================
// Module   : serial_mag_comparator
// Purpose  : Compares two WIDTH-bit unsigned operands two bits per cycle,
//            MSB pair first, by time-sharing a single cmp2_slice. Start/done
//            handshake; one-hot gt/lt/eq result held until the next
//            comparison completes.
// Config   : SERIAL_CMP_EARLY_EXIT_EN - when defined, leave RUN on the first
//            differing pair instead of always walking all WIDTH/2 pairs.
// Params   : WIDTH  operand width, even and >= 2
// Ports    : clk          rising-edge clock
//            rst_n        synchronous active-low reset
//            i_start      request, accepted only in IDLE
//            i_a, i_b     operands, sampled on the accepting edge
//            o_busy       high while in RUN
//            o_done       one-cycle pulse, result valid
//            o_gt/o_lt/o_eq  one-hot comparison result
// Revision : 1.0 - initial release
// ============================================================================
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_gt,
  output logic             o_lt,
  output logic             o_eq
);

  localparam int c_NPAIRS = WIDTH / 2;
  localparam int c_IDXW   = idx_width(c_NPAIRS);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [c_IDXW-1:0]  r_idx;
  logic               r_decided;
  logic               r_gt_st;
  logic               r_lt_st;
  logic               r_gt;
  logic               r_lt;
  logic               r_eq;

  logic [1:0]         w_pa;
  logic [1:0]         w_pb;
  cmp_res_t           w_slice;
  logic               w_hit;
  logic               w_last;
  logic               w_run_done;
  logic               w_dec_nxt;
  logic               w_gt_nxt;
  logic               w_lt_nxt;

  // Pair select: route pair r_idx of the latched operands into the slice.
  always_comb begin
    w_pa = 2'b00;
    w_pb = 2'b00;
    for (int k = 0; k < c_NPAIRS; k++) begin
      if (r_idx == c_IDXW'(k)) begin
        w_pa = r_a[2*k +: 2];
        w_pb = r_b[2*k +: 2];
      end
    end
  end

  cmp2_slice u_slice (
    .i_a   (w_pa),
    .i_b   (w_pb),
    .o_res (w_slice)
  );

  // First unequal pair seen from the MSB side decides; later pairs are
  // ignored once r_decided is set.
  assign w_hit     = !r_decided && (w_slice != CMP_EQ);
  assign w_last    = (r_idx == '0);
  assign w_dec_nxt = r_decided | w_hit;
  assign w_gt_nxt  = w_hit ? (w_slice == CMP_GT) : r_gt_st;
  assign w_lt_nxt  = w_hit ? (w_slice == CMP_LT) : r_lt_st;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign w_run_done = w_last | w_hit;
`else
  assign w_run_done = w_last;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start)    w_state_nxt = RUN;
      RUN:     if (w_run_done) w_state_nxt = FIN;
      FIN:                     w_state_nxt = IDLE;
      default:                 w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_decided <= 1'b0;
      r_gt_st   <= 1'b0;
      r_lt_st   <= 1'b0;
      r_gt      <= 1'b0;
      r_lt      <= 1'b0;
      r_eq      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          // Result outputs are deliberately left alone here: the previous
          // answer stays visible until this comparison finishes.
          if (i_start) begin
            r_a       <= i_a;
            r_b       <= i_b;
            r_idx     <= c_IDXW'(c_NPAIRS - 1);
            r_decided <= 1'b0;
            r_gt_st   <= 1'b0;
            r_lt_st   <= 1'b0;
          end
        end
        RUN: begin
          r_decided <= w_dec_nxt;
          r_gt_st   <= w_gt_nxt;
          r_lt_st   <= w_lt_nxt;
          if (!w_last) begin
            r_idx <= r_idx - c_IDXW'(1);
          end
          // Publish the final sticky result on the edge entering FIN so the
          // outputs are already valid in the cycle that done is high.
          if (w_run_done) begin
            r_gt <= w_gt_nxt;
            r_lt <= w_lt_nxt;
            r_eq <= ~w_dec_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy = (r_state == RUN);
  assign o_done = (r_state == FIN);
  assign o_gt   = r_gt;
  assign o_lt   = r_lt;
  assign o_eq   = r_eq;

endmodule

`default_nettype wire

// File: tb/tb_serial_mag_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_mag_comparator
// Purpose  : Directed self-checking bench for serial_mag_comparator. One
//            WIDTH=8 instance for the directed scenarios and one WIDTH=2
//            instance for the exhaustive small-width sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_mag_comparator;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic       o_busy, o_done, o_gt, o_lt, o_eq;

  logic       i_start2;
  logic [1:0] i_a2;
  logic [1:0] i_b2;
  logic       o_busy2, o_done2, o_gt2, o_lt2, o_eq2;

  int n_vec;
  int n_err;

  serial_mag_comparator #(.WIDTH(8)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_gt    (o_gt),
    .o_lt    (o_lt),
    .o_eq    (o_eq)
  );

  serial_mag_comparator #(.WIDTH(2)) u_dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start2),
    .i_a     (i_a2),
    .i_b     (i_b2),
    .o_busy  (o_busy2),
    .o_done  (o_done2),
    .o_gt    (o_gt2),
    .o_lt    (o_lt2),
    .o_eq    (o_eq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus driver (no checking): issues one start pulse and watches 12
  // samples, taken 1 time unit after each rising edge starting with the
  // accepting edge (sample c=1). Latency c means done was seen in sample c.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      output int lat, output int ndone, output int nbusy,
                      output int nover, output logic [2:0] res_done,
                      output logic [2:0] res_c1);
    lat = 0; ndone = 0; nbusy = 0; nover = 0;
    res_done = 3'bxxx; res_c1 = 3'bxxx;
    @(negedge clk);
    i_start = 1'b1; i_a = a; i_b = b;
    @(posedge clk); #1;
    i_start = 1'b0; i_a = ~a; i_b = ~b;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      if (c == 1) res_c1 = {o_gt, o_lt, o_eq};
      if (o_busy) nbusy++;
      if (o_busy && o_done) nover++;
      if (o_done) begin
        ndone++;
        if (lat == 0) begin
          lat = c;
          res_done = {o_gt, o_lt, o_eq};
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_a = 8'h00; i_b = 8'h00;
    i_start2 = 1'b0; i_a2 = 2'b00; i_b2 = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({o_busy, o_done, o_gt, o_lt, o_eq} !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_w8: got %b want 00000", {o_busy, o_done, o_gt, o_lt, o_eq});
    end
    n_vec++;
    if ({o_busy2, o_done2, o_gt2, o_lt2, o_eq2} !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_w2: got %b want 00000", {o_busy2, o_done2, o_gt2, o_lt2, o_eq2});
    end
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] res;    // {gt, lt, eq}
    int         lat_ee; // latency with early exit
    int         lat_fx; // latency without early exit
  } vec_t;

  task automatic test_directed();
    vec_t       tbl [8];
    logic [2:0] prev;
    int         lat, ndone, nbusy, nover, exp_lat;
    logic [2:0] rd, rc1;
    tbl[0] = '{8'hA5, 8'hA5, 3'b001, 5, 5};
    tbl[1] = '{8'h80, 8'h7F, 3'b100, 2, 5};
    tbl[2] = '{8'h12, 8'h13, 3'b010, 5, 5};
    tbl[3] = '{8'h40, 8'h80, 3'b010, 2, 5};
    tbl[4] = '{8'h24, 8'h28, 3'b010, 4, 5};
    tbl[5] = '{8'h30, 8'h0F, 3'b100, 3, 5};
    tbl[6] = '{8'hFF, 8'hFF, 3'b001, 5, 5};
    tbl[7] = '{8'h00, 8'hFF, 3'b010, 2, 5};
    prev = 3'b000;
    for (int i = 0; i < 8; i++) begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      exp_lat = tbl[i].lat_ee;
`else
      exp_lat = tbl[i].lat_fx;
`endif
      run8(tbl[i].a, tbl[i].b, lat, ndone, nbusy, nover, rd, rc1);
      n_vec++;
      if (rc1 !== prev) begin
        n_err++;
        $display("FAIL vec%0d_hold_on_start: got %b want %b", i, rc1, prev);
      end
      n_vec++;
      if (lat !== exp_lat) begin
        n_err++;
        $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, exp_lat);
      end
      n_vec++;
      if (rd !== tbl[i].res) begin
        n_err++;
        $display("FAIL vec%0d_result: got %b want %b", i, rd, tbl[i].res);
      end
      n_vec++;
      if (ndone !== 1) begin
        n_err++;
        $display("FAIL vec%0d_done_count: got %0d want 1", i, ndone);
      end
      n_vec++;
      if (nbusy !== exp_lat - 1) begin
        n_err++;
        $display("FAIL vec%0d_busy_cycles: got %0d want %0d", i, nbusy, exp_lat - 1);
      end
      n_vec++;
      if (nover !== 0) begin
        n_err++;
        $display("FAIL vec%0d_busy_done_overlap: got %0d want 0", i, nover);
      end
      n_vec++;
      if ({o_gt, o_lt, o_eq} !== tbl[i].res) begin
        n_err++;
        $display("FAIL vec%0d_result_held: got %b want %b", i, {o_gt, o_lt, o_eq}, tbl[i].res);
      end
      prev = tbl[i].res;
    end
  endtask

  // start held high across a whole comparison, operands changed in RUN
  task automatic test_start_held();
    int         lat, ndone, lat2;
    logic [2:0] rd, rd2;
    lat = 0; ndone = 0; rd = 3'bxxx;
    @(negedge clk);
    i_start = 1'b1; i_a = 8'h01; i_b = 8'h00;
    @(posedge clk); #1;
    i_a = 8'hFF; i_b = 8'hFF;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      if (o_done) begin
        ndone++;
        if (lat == 0) begin
          lat = c;
          rd = {o_gt, o_lt, o_eq};
        end
      end
    end
    n_vec++;
    if ({o_busy, o_done} !== 2'b00) begin
      n_err++;
      $display("FAIL held_idle_after_fin: busy,done got %b want 00", {o_busy, o_done});
    end
    @(posedge clk); #1;
    n_vec++;
    if (o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL held_reaccept_in_idle: busy got %b want 1", o_busy);
    end
    i_start = 1'b0;
    n_vec++;
    if (ndone !== 1) begin
      n_err++;
      $display("FAIL held_done_count: got %0d want 1", ndone);
    end
    n_vec++;
    if (lat !== 5) begin
      n_err++;
      $display("FAIL held_latency: got %0d want 5", lat);
    end
    n_vec++;
    if (rd !== 3'b100) begin
      n_err++;
      $display("FAIL held_result: got %b want 100", rd);
    end
    // second comparison captured FF/FF at the re-accept edge
    lat2 = 0; rd2 = 3'bxxx;
    for (int c = 2; c <= 10; c++) begin
      @(posedge clk); #1;
      if (o_done && lat2 == 0) begin
        lat2 = c;
        rd2 = {o_gt, o_lt, o_eq};
      end
    end
    n_vec++;
    if (lat2 !== 5) begin
      n_err++;
      $display("FAIL held_second_latency: got %0d want 5", lat2);
    end
    n_vec++;
    if (rd2 !== 3'b001) begin
      n_err++;
      $display("FAIL held_second_result: got %b want 001", rd2);
    end
  endtask

  task automatic test_reset_mid_run();
    int         ndone, lat, nd2, nbusy, nover, exp_lat;
    logic [2:0] rd, rc1;
    @(negedge clk);
    i_start = 1'b1; i_a = 8'h12; i_b = 8'h13;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL midrun_busy_before_reset: got %b want 1", o_busy);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_vec++;
    if ({o_busy, o_done, o_gt, o_lt, o_eq} !== 5'b00000) begin
      n_err++;
      $display("FAIL midrun_outputs_after_reset: got %b want 00000", {o_busy, o_done, o_gt, o_lt, o_eq});
    end
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (o_done) ndone++;
    end
    n_vec++;
    if (ndone !== 0) begin
      n_err++;
      $display("FAIL midrun_no_done: got %0d want 0", ndone);
    end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    exp_lat = 3;
`else
    exp_lat = 5;
`endif
    run8(8'h03, 8'h30, lat, nd2, nbusy, nover, rd, rc1);
    n_vec++;
    if (rc1 !== 3'b000) begin
      n_err++;
      $display("FAIL post_reset_hold: got %b want 000", rc1);
    end
    n_vec++;
    if (lat !== exp_lat) begin
      n_err++;
      $display("FAIL post_reset_latency: got %0d want %0d", lat, exp_lat);
    end
    n_vec++;
    if (rd !== 3'b010) begin
      n_err++;
      $display("FAIL post_reset_result: got %b want 010", rd);
    end
  endtask

  task automatic test_width2_exhaustive();
    int         lat;
    logic [2:0] rd, exp_res;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        exp_res = {(a > b), (a < b), (a == b)};
        lat = 0; rd = 3'bxxx;
        @(negedge clk);
        i_start2 = 1'b1; i_a2 = 2'(a); i_b2 = 2'(b);
        @(posedge clk); #1;
        i_start2 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
          if (c > 1) begin
            @(posedge clk); #1;
          end
          if (o_done2 && lat == 0) begin
            lat = c;
            rd = {o_gt2, o_lt2, o_eq2};
          end
        end
        n_vec++;
        if (lat !== 2) begin
          n_err++;
          $display("FAIL w2_latency a=%0d b=%0d: got %0d want 2", a, b, lat);
        end
        n_vec++;
        if (rd !== exp_res) begin
          n_err++;
          $display("FAIL w2_result a=%0d b=%0d: got %b want %b", a, b, rd, exp_res);
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_start_held();
    test_reset_mid_run();
    test_width2_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
